// File: rtl/write_back_arbiter.sv
// -----------------------------------------------------------------------------
// write_back_arbiter
//
// Merges register-file writes from the ALU result path and the memory-load
// path onto the single regFile write port. ALU results win every cycle they
// are present and are never stalled; load results are buffered in a small
// FIFO behind a valid/ready handshake and drain in arrival order whenever the
// ALU leaves the port idle. A combinational query port reports whether a
// register still has a write in flight (queued or sitting in the output
// register) so decode can stall on RAW/WAW hazards.
//
// Register 0 is hardwired zero: requests targeting it are accepted and
// dropped, so they never occupy a FIFO slot or drive the write port.
//
// Ports
//   clk_i           clock, all state updates on the rising edge
//   rstN_i          asynchronous active-low reset
//   aluValid_i      ALU result present this cycle
//   aluReg_i        ALU destination register
//   aluData_i       ALU result data
//   memValid_i      load result offered
//   memReady_o      FIFO can accept (occupancy only, never depends on valid)
//   memReg_i        load destination register
//   memData_i       load data
//   queryReg_i      register index to check for pending writes
//   queryPending_o  a write to queryReg_i is still in flight (combinational)
//   writeEnable_o   registered regFile write enable
//   writeReg_o      registered regFile write index
//   writeData_o     registered regFile write data
//   count_o         current FIFO occupancy
// -----------------------------------------------------------------------------
module write_back_arbiter #(
   parameter int n     = 32,
   parameter int r     = 7,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rstN_i,
   input  logic                     aluValid_i,
   input  logic [r-1:0]             aluReg_i,
   input  logic [n-1:0]             aluData_i,
   input  logic                     memValid_i,
   output logic                     memReady_o,
   input  logic [r-1:0]             memReg_i,
   input  logic [n-1:0]             memData_i,
   input  logic [r-1:0]             queryReg_i,
   output logic                     queryPending_o,
   output logic                     writeEnable_o,
   output logic [r-1:0]             writeReg_o,
   output logic [n-1:0]             writeData_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   // FIFO storage. Payload carries no reset; only the valid bits matter for
   // the hazard query and they are cleared asynchronously.
   logic [r-1:0]     ent_reg_q  [DEPTH];
   logic [n-1:0]     ent_data_q [DEPTH];
   logic [DEPTH-1:0] ent_valid_q, ent_valid_d;

   logic [AW-1:0]    head_q, head_d;
   logic [AW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;

   logic             we_q, we_d;
   logic [r-1:0]     wreg_q, wreg_d;
   logic [n-1:0]     wdata_q, wdata_d;

   logic             alu_sel;
   logic             fifo_empty;
   logic             fifo_full;
   logic             mem_ready;
   logic             push;
   logic             pop;
   logic             query_hit;

   // --------------------------------------------------------------------------
   // Handshake and arbitration decisions
   // --------------------------------------------------------------------------
   always_comb begin
      fifo_empty = (count_q == '0);
      fifo_full  = (count_q == FULL_CNT);

      // Readiness is purely occupancy based: a pop in the same cycle does not
      // reopen a full FIFO, which keeps memReady free of any path from the
      // ALU inputs.
      mem_ready  = rstN_i && !fifo_full;

      alu_sel    = aluValid_i && (aluReg_i != '0);

      // Writes to register 0 complete the handshake but are never stored.
      push       = memValid_i && mem_ready && (memReg_i != '0);

      // Pop is based on registered occupancy, so an entry written this edge
      // cannot leave until the next one (no bypass).
      pop        = !alu_sel && !fifo_empty;
   end

   // --------------------------------------------------------------------------
   // Next-state: output register, pointers, occupancy, valid bits
   // --------------------------------------------------------------------------
   always_comb begin
      we_d        = 1'b0;
      wreg_d      = wreg_q;
      wdata_d     = wdata_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      ent_valid_d = ent_valid_q;

      if (alu_sel) begin
         we_d    = 1'b1;
         wreg_d  = aluReg_i;
         wdata_d = aluData_i;
      end else if (pop) begin
         we_d    = 1'b1;
         wreg_d  = ent_reg_q[head_q];
         wdata_d = ent_data_q[head_q];
      end

      if (pop) begin
         ent_valid_d[head_q] = 1'b0;
         head_d              = head_q + AW'(1);
      end

      // Push and pop never target the same slot: a pop needs count >= 1 and
      // a push needs count < DEPTH, so head != tail whenever both happen.
      if (push) begin
         ent_valid_d[tail_q] = 1'b1;
         tail_d              = tail_q + AW'(1);
      end

      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // --------------------------------------------------------------------------
   // State registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rstN_i) begin
      if (!rstN_i) begin
         we_q        <= 1'b0;
         wreg_q      <= '0;
         wdata_q     <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         ent_valid_q <= '0;
      end else begin
         we_q        <= we_d;
         wreg_q      <= wreg_d;
         wdata_q     <= wdata_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         ent_valid_q <= ent_valid_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         ent_reg_q[tail_q]  <= memReg_i;
         ent_data_q[tail_q] <= memData_i;
      end
   end

   // --------------------------------------------------------------------------
   // Hazard query: any queued load or the write currently on the port
   // --------------------------------------------------------------------------
   always_comb begin
      query_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_valid_q[i] && (ent_reg_q[i] == queryReg_i)) begin
            query_hit = 1'b1;
         end
      end
      if (we_q && (wreg_q == queryReg_i)) begin
         query_hit = 1'b1;
      end
      queryPending_o = (queryReg_i != '0) && query_hit;
   end

   assign memReady_o    = mem_ready;
   assign writeEnable_o = we_q;
   assign writeReg_o    = wreg_q;
   assign writeData_o   = wdata_q;
   assign count_o       = count_q;

endmodule

// File: tb/tb_write_back_arbiter.sv
module tb_write_back_arbiter;

   localparam int N     = 32;
   localparam int R     = 7;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rstN;
   logic          aluValid;
   logic [R-1:0]  aluReg;
   logic [N-1:0]  aluData;
   logic          memValid;
   logic          memReady;
   logic [R-1:0]  memReg;
   logic [N-1:0]  memData;
   logic [R-1:0]  queryReg;
   logic          queryPending;
   logic          writeEnable;
   logic [R-1:0]  writeReg;
   logic [N-1:0]  writeData;
   logic [CW-1:0] count;

   always #5 clk = ~clk;

   write_back_arbiter #(.n(N), .r(R), .DEPTH(DEPTH)) dut (
      .clk_i          (clk),
      .rstN_i         (rstN),
      .aluValid_i     (aluValid),
      .aluReg_i       (aluReg),
      .aluData_i      (aluData),
      .memValid_i     (memValid),
      .memReady_o     (memReady),
      .memReg_i       (memReg),
      .memData_i      (memData),
      .queryReg_i     (queryReg),
      .queryPending_o (queryPending),
      .writeEnable_o  (writeEnable),
      .writeReg_o     (writeReg),
      .writeData_o    (writeData),
      .count_o        (count)
   );

   typedef struct packed {
      logic [R-1:0] r;
      logic [N-1:0] d;
   } ent_t;

   typedef struct packed {
      logic          we;
      logic [R-1:0]  r;
      logic [N-1:0]  d;
      logic [CW-1:0] cnt;
   } exp_t;

   // Reference model: load queue plus the value the write port should hold.
   ent_t         mfifo[$];
   exp_t         expq[$];
   logic         m_we;
   logic [R-1:0] m_reg;
   logic [N-1:0] m_data;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
      end
   endtask

   function automatic logic model_pending(input logic [R-1:0] q);
      if (q == '0) return 1'b0;
      foreach (mfifo[i]) if (mfifo[i].r == q) return 1'b1;
      return m_we && (m_reg == q);
   endfunction

   // One clock of stimulus: drive at the falling edge, check the combinational
   // outputs against the model's current state, then advance the model to the
   // state expected after the next rising edge and hand it to the monitor.
   task automatic cycle(input logic av, input logic [R-1:0] ar, input logic [N-1:0] ad,
                        input logic mv, input logic [R-1:0] mr, input logic [N-1:0] md,
                        input logic [R-1:0] qr, output logic acc);
      ent_t e;
      exp_t x;
      logic rdy;
      @(negedge clk);
      rstN     = 1'b1;
      aluValid = av;
      aluReg   = ar;
      aluData  = ad;
      memValid = mv;
      memReg   = mr;
      memData  = md;
      queryReg = qr;
      #1;
      rdy = (mfifo.size() != DEPTH);
      chk("memReady", memReady, rdy);
      chk("queryPending", queryPending, model_pending(qr));
      acc = mv && rdy;
      if (av && ar != '0) begin
         m_we = 1'b1; m_reg = ar; m_data = ad;
      end else if (mfifo.size() > 0) begin
         e = mfifo.pop_front();
         m_we = 1'b1; m_reg = e.r; m_data = e.d;
      end else begin
         m_we = 1'b0;
      end
      if (acc && mr != '0) begin
         e.r = mr;
         e.d = md;
         mfifo.push_back(e);
      end
      x.we  = m_we;
      x.r   = m_reg;
      x.d   = m_data;
      x.cnt = CW'(mfifo.size());
      expq.push_back(x);
   endtask

   task automatic idle(input logic [R-1:0] qr);
      logic a;
      cycle(1'b0, '0, '0, 1'b0, '0, '0, qr, a);
   endtask

   task automatic do_reset(input int hold);
      @(negedge clk);
      rstN = 1'b0;
      #1;
      chk("rst_writeEnable", writeEnable, 1'b0);
      chk("rst_writeReg", writeReg, '0);
      chk("rst_writeData", writeData, '0);
      chk("rst_count", count, '0);
      chk("rst_memReady", memReady, 1'b0);
      mfifo.delete();
      m_we = 1'b0; m_reg = '0; m_data = '0;
      repeat (hold) @(negedge clk);
   endtask

   // Monitor: every rising edge out of reset must match the next expectation.
   exp_t mon_x;
   always @(posedge clk) begin
      #1;
      if (rstN) begin
         if (expq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL monitor_underflow: got no expectation at %0t", $time);
         end else begin
            mon_x = expq.pop_front();
            chk("writeEnable", writeEnable, mon_x.we);
            chk("writeReg", writeReg, mon_x.r);
            chk("writeData", writeData, mon_x.d);
            chk("count", count, mon_x.cnt);
         end
      end
   end

   initial begin
      logic         acc;
      int           accepted;
      logic [R-1:0] load_regs [3];
      rstN = 1'b0; aluValid = 1'b0; aluReg = '0; aluData = '0;
      memValid = 1'b0; memReg = '0; memData = '0; queryReg = '0;
      m_we = 1'b0; m_reg = '0; m_data = '0;
      #1;
      chk("init_writeEnable", writeEnable, 1'b0);
      chk("init_count", count, '0);
      chk("init_memReady", memReady, 1'b0);
      repeat (2) @(negedge clk);

      // ALU path
      cycle(1'b1, 7'd5, 32'hDEADBEEF, 1'b0, '0, '0, '0, acc);
      idle('0);
      idle('0);

      // Loads behind four cycles of ALU traffic to reg 9
      load_regs[0] = 7'd3; load_regs[1] = 7'd4; load_regs[2] = 7'd6;
      for (int i = 0; i < 4; i++)
         cycle(1'b1, 7'd9, 32'h900 + i, i < 3, (i < 3) ? load_regs[i] : 7'd0,
               32'hA000 + i, 7'd4, acc);
      repeat (5) idle(7'd4);

      // Fill to full under ALU pressure; the fifth offer must be refused
      for (int i = 0; i < 5; i++)
         cycle(1'b1, 7'd9, 32'hB00 + i, 1'b1, 7'd20 + 7'(i), 32'hC000 + i, 7'd20, acc);
      // Release the ALU, push eight more across the pointer wrap
      accepted = 0;
      for (int k = 0; k < 60 && accepted < 8; k++) begin
         cycle(1'b0, '0, '0, 1'b1, 7'd30 + 7'(accepted), 32'hD000 + accepted, 7'd30, acc);
         if (acc) accepted++;
      end
      if (accepted != 8) begin
         total++;
         bad++;
         $display("FAIL wrap_accept: got %0d expected 8", accepted);
      end
      repeat (6) idle('0);

      // Register 0: load dropped, ALU-to-0 lets the FIFO pop
      cycle(1'b0, '0, '0, 1'b1, 7'd0, 32'h1234, '0, acc);
      cycle(1'b1, 7'd9, 32'h1, 1'b1, 7'd7, 32'h77, 7'd7, acc);
      cycle(1'b1, 7'd9, 32'h2, 1'b1, 7'd8, 32'h88, 7'd7, acc);
      cycle(1'b1, 7'd0, 32'h3, 1'b0, '0, '0, 7'd8, acc);
      repeat (3) idle(7'd8);

      // Query on reg 4 while its load waits, sits on the port, then leaves
      cycle(1'b1, 7'd9, 32'h5, 1'b1, 7'd4, 32'h44, 7'd4, acc);
      repeat (3) cycle(1'b1, 7'd10, 32'h6, 1'b0, '0, '0, 7'd4, acc);
      repeat (4) idle(7'd4);

      // Reset mid-drain with three loads queued
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 7'd9, 32'hE0 + i, 1'b1, 7'd11 + 7'(i), 32'hF0 + i, '0, acc);
      do_reset(2);
      for (int q = 0; q < (1 << R); q++) idle(7'(q));

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         logic         av, mv;
         logic [R-1:0] ar, mr, qr;
         av = ($urandom_range(0, 99) < 40);
         ar = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 15));
         mv = ($urandom_range(0, 99) < 60);
         mr = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 15));
         qr = ($urandom_range(0, 15) == 0) ? 7'($urandom_range(0, 127))
                                           : 7'($urandom_range(0, 15));
         if ($urandom_range(0, 499) == 0) do_reset(1);
         cycle(av, ar, $urandom(), mv, mr, $urandom(), qr, acc);
      end
      repeat (4) idle('0);

      @(posedge clk);
      #2;
      if (expq.size() != 0) begin
         total++;
         bad++;
         $display("FAIL leftover_expect: got %0d expected 0", expq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/write_back_arbiter.md
# write_back_arbiter

Merges register-file write requests from the ALU result path and the memory-load path onto the register file's single write port. ALU results have strict priority and are never stalled. Load results pass through a small FIFO with a valid/ready handshake. A query port reports whether a register still has a write in flight, so decode can stall on read-after-write and write-after-write hazards. Sits directly upstream of regFile: its outputs drive regFile's writeEnable, writeReg and writeData.

## Interface
- n, 32, data width (matches regFile)
- r, 7, register index width (2**r registers)
- DEPTH, 4, load FIFO entries; power of two, >= 2
- clk  in  1  clock; all state updates on rising edge
- rstN  in  1  asynchronous, active-low reset
- aluValid  in  1  ALU result present this cycle
- aluReg  in  r  ALU destination register
- aluData  in  n  ALU result
- memValid  in  1  load result offered
- memReady  out  1  FIFO can accept; a transfer occurs when memValid && memReady at a rising edge
- memReg  in  r  load destination register
- memData  in  n  load data
- queryReg  in  r  register index to check for pending writes
- queryPending  out  1  combinational; a write to queryReg is still in flight
- writeEnable  out  1  registered; to regFile writeEnable
- writeReg  out  r  registered; to regFile writeReg
- writeData  out  n  registered; to regFile writeData
- count  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Register 0 is hardwired zero. Any request with destination 0 is accepted and discarded; it never reaches the FIFO or the outputs.
- **Load enqueue:**
  - memReady = rstN && (count != DEPTH). It depends only on occupancy and is never dependent on memValid.
  - When full, memReady stays 0 even if a pop happens in the same cycle.
  - On a transfer with memReg != 0, {memReg, memData} is written at the tail, and the tail pointer advances modulo DEPTH.
- **Output selection, evaluated each rising edge:**
  - If aluValid && aluReg != 0: load the output register with the ALU request and set writeEnable = 1. The FIFO does not pop.
  - Else, if the FIFO is non-empty: pop the head into the output register, set writeEnable = 1, and advance the head modulo DEPTH.
  - Else: writeEnable = 0. writeReg and writeData hold their previous values.
- **No bypass:** an entry enqueued at edge t can be popped at edge t+1 at the earliest.
- **Simultaneous push and pop** (not full): count is unchanged; both pointers advance.
- **queryPending** = (queryReg != 0) && (any valid FIFO entry has reg == queryReg, or (writeEnable && writeReg == queryReg)).
- **Ordering:**
  - Loads drain in arrival order.
  - An ALU request may overtake queued loads. Upstream must use queryPending to avoid issuing an ALU write to a register with a pending load.
  - The block does not reorder or squash such conflicts.

## Timing
- **Reset (asynchronous):**
  - writeEnable = 0, writeReg = 0, writeData = 0, count = 0.
  - Head and tail pointers = 0; all FIFO entries invalid.
  - memReady = 0 while rstN is low, and 1 from the first cycle after release.
  - Reset mid-drain discards all queued loads.
- **ALU latency:** request sampled at edge t; writeEnable/writeReg/writeData valid after edge t; regFile commits at edge t+1.
- **Load latency:** minimum 2 edges from transfer to output (enqueue at t, pop at t+1). With ALU traffic, a load waits until the first edge with no qualifying ALU request.
- **Starvation:** continuous ALU traffic can starve loads indefinitely. The FIFO then fills and memReady drops.
- **Throughput:** at most one register write per cycle; at most one load transfer per cycle.

## Test plan
- **Reset state:** assert rstN=0 mid-operation with count=3 → outputs immediately 0, count=0, memReady=0; after release memReady=1 and queryPending=0 for every queryReg.
- **ALU path:** aluValid=1, aluReg=5, aluData=0xDEADBEEF at edge t → after edge t: writeEnable=1, writeReg=5, writeData=0xDEADBEEF; next edge with aluValid=0 and FIFO empty → writeEnable=0.
- **Load path and priority:**
  - Push loads to regs 3, 4, 6 in consecutive cycles while aluValid=1 (reg 9) for 4 cycles → writeEnable carries reg 9 for 4 cycles.
  - Loads then appear as 3, 4, 6 on the following 3 edges; count goes 1, 2, 3, then back down to 0.
- **Full boundary and wrap:**
  - DEPTH=4, ALU busy: push 4 loads → count=4, memReady=0, and a fifth memValid is not accepted.
  - Release the ALU and push 8 more loads interleaved with pops → all 12 emerge in order across the pointer wrap.
- **Register 0 and query:**
  - Load to reg 0 → accepted (memReady=1), count unchanged, never written. ALU to reg 0 with a non-empty FIFO → FIFO pops that cycle.
  - queryReg=4 → queryPending=1 while a reg-4 load is queued or in the output register, and 0 on the cycle after it leaves the output register.
